// File: rtl/sink_e_pkg.sv
// Shared sizing and types for the sink-ID / GrantAck tracker.
// Other files import this package for defaults and helpers.
package sink_e_pkg;

  localparam int SINK_BITS_DEF = 3;
  localparam int NUM_SINKS_DEF = 2 ** SINK_BITS_DEF;

  typedef logic [SINK_BITS_DEF-1:0] sink_id_t;

  function automatic int num_sinks(input int bits);
    return 2 ** bits;
  endfunction

endpackage

// File: rtl/sink_e_tracker_if.sv
// Allocation, GrantAck and release-notification signals of the sink tracker.
// The slave modport belongs to the tracker; the master modport drives the tracker.
interface sink_e_tracker_if
  import sink_e_pkg::*;
#(
  parameter int SINK_BITS = SINK_BITS_DEF
);

  logic                 io_alloc_valid;
  logic                 io_alloc_ready;
  logic [SINK_BITS-1:0] io_alloc_sink;
  logic                 io_e_valid;
  logic                 io_e_ready;
  logic [SINK_BITS-1:0] io_e_bits_sink;
  logic                 io_resp_valid;
  logic                 io_resp_ready;
  logic [SINK_BITS-1:0] io_resp_bits_sink;
  logic [SINK_BITS:0]   io_inflight;
  logic                 io_busy;
  logic                 io_err;

  modport slave (
    input  io_alloc_valid, io_e_valid, io_e_bits_sink, io_resp_ready,
    output io_alloc_ready, io_alloc_sink, io_e_ready, io_resp_valid,
           io_resp_bits_sink, io_inflight, io_busy, io_err
  );

  modport master (
    output io_alloc_valid, io_e_valid, io_e_bits_sink, io_resp_ready,
    input  io_alloc_ready, io_alloc_sink, io_e_ready, io_resp_valid,
           io_resp_bits_sink, io_inflight, io_busy, io_err
  );

endinterface

// File: rtl/sink_e_resp_fifo.sv
// Small FIFO holding released sink IDs until the consumer takes them.
// The head reads as zero while the FIFO is empty.
module sink_e_resp_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;
  assign head    = valid ? mem_reg[rd_ptr_reg] : '0;

  // Storage needs no reset: stale entries are hidden by the occupancy count.
  always_ff @(posedge clock) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sink_e_tracker.sv
// Tracks which D-channel sink IDs await GrantAck, hands out the lowest free ID,
// and queues each acknowledged ID as a release notification.
module sink_e_tracker
  import sink_e_pkg::*;
#(
  parameter int SINK_BITS  = SINK_BITS_DEF,
  parameter int RESP_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  sink_e_tracker_if.slave  bus
);

  localparam int NUM_SINKS = num_sinks(SINK_BITS);

  logic [NUM_SINKS-1:0] vec_reg, vec_next, set_vec, clr_vec;
  logic [SINK_BITS:0]   inflight_reg;
  logic                 err_reg;
  logic [SINK_BITS-1:0] free_sink;
  logic                 alloc_fire, e_fire, ack_legal, fifo_full;

  // Lowest clear bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    free_sink = '0;
    for (int i = NUM_SINKS - 1; i >= 0; i--) begin
      if (!vec_reg[i]) free_sink = SINK_BITS'(i);
    end
  end

  assign bus.io_alloc_ready = ~&vec_reg;
  assign bus.io_alloc_sink  = free_sink;
  assign bus.io_e_ready     = !fifo_full;
  assign bus.io_inflight    = inflight_reg;
  assign bus.io_busy        = (inflight_reg != '0);
  assign bus.io_err         = err_reg;

  assign alloc_fire = bus.io_alloc_valid && bus.io_alloc_ready;
  assign e_fire     = bus.io_e_valid && bus.io_e_ready;
  assign ack_legal  = e_fire && vec_reg[bus.io_e_bits_sink];

  generate
    for (genvar gi = 0; gi < NUM_SINKS; gi++) begin : g_bit
      assign set_vec[gi] = alloc_fire && (free_sink == SINK_BITS'(gi));
      assign clr_vec[gi] = ack_legal && (bus.io_e_bits_sink == SINK_BITS'(gi));
    end
  endgenerate

  // An ack of the ID being allocated this cycle is illegal, so clear never meets set.
  assign vec_next = (vec_reg & ~clr_vec) | set_vec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vec_reg      <= '0;
      inflight_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      vec_reg <= vec_next;
      if (e_fire && !vec_reg[bus.io_e_bits_sink]) err_reg <= 1'b1;
      case ({alloc_fire, ack_legal})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  sink_e_resp_fifo #(
    .WIDTH (SINK_BITS),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ack_legal),
    .push_data (bus.io_e_bits_sink),
    .pop       (bus.io_resp_ready),
    .full      (fifo_full),
    .valid     (bus.io_resp_valid),
    .head      (bus.io_resp_bits_sink)
  );

endmodule

// File: doc/sink_e_tracker.md
SINK_E_TRACKER -- requirements
Module: sink_e_tracker

Interface
REQ-001 SHALL provide parameter SINK_BITS, default 3, width of sink ID; NUM_SINKS = 2**SINK_BITS.
REQ-002 SHALL provide parameter RESP_DEPTH, default 2, entries in response FIFO (>=1).
REQ-003 SHALL have one clock and an asynchronous, active-high reset, ports named clock and reset.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 io_alloc_valid  input  1  D-channel Grant issued; consume offered sink ID.
REQ-007 io_alloc_ready  output  1  at least one sink ID free.
REQ-008 io_alloc_sink  output  SINK_BITS  lowest-index free sink ID offered.
REQ-009 io_e_valid  input  1  GrantAck beat present.
REQ-010 io_e_ready  output  1  GrantAck accepted this cycle when high with valid.
REQ-011 io_e_bits_sink  input  SINK_BITS  sink ID being acknowledged.
REQ-012 io_resp_valid  output  1  release notification valid.
REQ-013 io_resp_ready  input  1  consumer accepts notification.
REQ-014 io_resp_bits_sink  output  SINK_BITS  released sink ID.
REQ-015 io_inflight  output  SINK_BITS+1  count of allocated, unacknowledged sink IDs.
REQ-016 io_busy  output  1  io_inflight != 0.
REQ-017 io_err  output  1  sticky: GrantAck received for a sink ID not in flight.

Function
REQ-018 SHALL hold a NUM_SINKS-bit in-flight vector; bit i set = sink i allocated, awaiting GrantAck.
REQ-019 io_alloc_ready SHALL be 1 iff any vector bit is clear; io_alloc_sink SHALL be lowest clear index (0 when none clear).
REQ-020 Alloc fire (valid && ready) SHALL set the offered bit, visible next cycle; io_alloc_valid with ready low SHALL have no effect.
REQ-021 io_e_ready SHALL be 1 iff FIFO occupancy < RESP_DEPTH (no same-cycle pass-through when full).
REQ-022 E fire with bit[io_e_bits_sink] set SHALL clear that bit and push the ID into the FIFO, next cycle.
REQ-023 E fire with bit clear SHALL set io_err next cycle, push nothing, leave vector unchanged.
REQ-024 Same-cycle alloc of X and legal ack of Y (X != Y) SHALL both take effect; io_inflight unchanged.
REQ-025 Same-cycle alloc of X and ack of X is illegal (bit clear at sample): SHALL set io_err; allocation of X still takes effect.
REQ-026 io_inflight SHALL update +1 / -1 / 0 per cycle from alloc fire and legal ack fire; never wraps (max NUM_SINKS).
REQ-027 Response FIFO SHALL be first-in first-out; io_resp_valid = occupancy != 0; head on io_resp_bits_sink; latency E fire to io_resp_valid exactly 1 cycle when empty.
REQ-028 Simultaneous push and pop SHALL keep occupancy; pointers SHALL wrap modulo RESP_DEPTH.
REQ-029 io_resp_bits_sink SHALL be 0 when FIFO empty.
REQ-030 io_err SHALL remain 1 until reset.

Reset
REQ-031 Reset SHALL asynchronously clear in-flight vector, FIFO pointers/occupancy, io_inflight and io_err.
REQ-032 During/after reset outputs SHALL be: io_alloc_ready=1, io_alloc_sink=0, io_e_ready=1, io_resp_valid=0, io_resp_bits_sink=0, io_inflight=0, io_busy=0, io_err=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight state and queued responses; no partial release emitted.

Structure
REQ-034 Package sink_e_pkg SHALL hold SINK_BITS default, NUM_SINKS derivation and sink-ID typedef.
REQ-035 Response FIFO SHALL be sub-module sink_e_resp_fifo (parameters WIDTH, DEPTH); priority encoder and counter SHALL be inline.

Verification
REQ-036 Reset, allocate 8 times back-to-back -> io_alloc_sink 0..7, io_inflight 8, io_alloc_ready 0 on 9th cycle.
REQ-037 All 8 allocated, ack sink 5 -> next cycle io_resp_valid=1, io_resp_bits_sink=5, io_alloc_sink=5, io_inflight=7.
REQ-038 RESP_DEPTH=2, io_resp_ready=0, acks 1,2 -> io_e_ready=0; then resp_ready=1 -> releases 1 then 2 in order, io_e_ready returns 1.
REQ-039 Reset, ack sink 3 (never allocated) -> io_err=1 next cycle, io_resp_valid stays 0, io_err held until reset.
REQ-040 Sinks 0,1 allocated; same cycle alloc (sink 2) and ack 0 -> io_inflight stays 2, vector = {1,2}, release 0 emitted.
REQ-041 Reset asserted with 4 in flight and 1 queued -> all outputs at REQ-032 values within same cycle.
